// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter: latches external interrupt lines, holds per-source
// enable/trigger/shv/level configuration and presents the highest-level
// eligible pending source to the core until it is acknowledged or withdrawn.
module clic_irq_arbiter #(
    parameter int unsigned NumSrc = 256,
    parameter int unsigned IdxW   = $clog2(NumSrc)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] src_i,
    input  logic              cfg_we_i,
    input  logic [IdxW-1:0]   cfg_idx_i,
    input  logic              cfg_ie_i,
    input  logic              cfg_edge_i,
    input  logic              cfg_shv_i,
    input  logic [7:0]        cfg_level_i,
    input  logic [7:0]        thresh_i,
    output logic [NumSrc-1:0] irq_o,
    output logic [IdxW-1:0]   irq_id_o,
    output logic [7:0]        irq_level_o,
    output logic              irq_shv_o,
    input  logic              irq_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Per-source configuration
    logic [NumSrc-1:0] ie_q, ie_d;
    logic [NumSrc-1:0] edge_q, edge_d;
    logic [NumSrc-1:0] shv_q, shv_d;
    logic [7:0]        level_q [NumSrc];
    logic [7:0]        level_d [NumSrc];

    // Line sampling and pending state
    logic [NumSrc-1:0] src_q, src_d;
    logic [NumSrc-1:0] pending_q, pending_d;

    // Presentation state
    state_e            state_q, state_d;
    logic [IdxW-1:0]   irq_id_q, irq_id_d;
    logic [7:0]        irq_level_q, irq_level_d;
    logic              irq_shv_q, irq_shv_d;

    // Arbitration results
    logic [NumSrc-1:0] eligible;
    logic              any_eligible;
    logic [IdxW-1:0]   win_idx;
    logic [7:0]        win_level;
    logic              ack_clear;
    logic              req_active;

    // Configuration write: only the addressed source's fields change.
    always_comb begin
        ie_d    = ie_q;
        edge_d  = edge_q;
        shv_d   = shv_q;
        level_d = level_q;
        if (cfg_we_i) begin
            ie_d[cfg_idx_i]    = cfg_ie_i;
            edge_d[cfg_idx_i]  = cfg_edge_i;
            shv_d[cfg_idx_i]   = cfg_shv_i;
            level_d[cfg_idx_i] = cfg_level_i;
        end
    end

    // Eligibility: pending, enabled and strictly above the core threshold.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NumSrc); i++) begin
            eligible[i] = pending_q[i] & ie_q[i] & (level_q[i] > thresh_i);
        end
    end

    // Winner search: highest level, ties resolved towards the higher index.
    always_comb begin
        any_eligible = 1'b0;
        win_idx      = '0;
        win_level    = '0;
        for (int i = 0; i < int'(NumSrc); i++) begin
            if (eligible[i] && (!any_eligible || level_q[i] >= win_level)) begin
                any_eligible = 1'b1;
                win_idx      = IdxW'(i);
                win_level    = level_q[i];
            end
        end
    end

    // Presentation FSM: pick in IDLE, hold in REQ, one quiet cycle in GAP.
    always_comb begin
        state_d     = state_q;
        irq_id_d    = irq_id_q;
        irq_level_d = irq_level_q;
        irq_shv_d   = irq_shv_q;
        ack_clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    state_d     = REQ;
                    irq_id_d    = win_idx;
                    irq_level_d = win_level;
                    irq_shv_d   = shv_q[win_idx];
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    ack_clear = edge_q[irq_id_q];
                    state_d   = GAP;
                end else if (!eligible[irq_id_q]) begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending update: level sources follow the line, edge sources latch a
    // rising edge and are cleared by an ack, with a new edge taking priority.
    always_comb begin
        src_d     = src_i;
        pending_d = '0;
        for (int i = 0; i < int'(NumSrc); i++) begin
            if (edge_q[i]) begin
                pending_d[i] = (src_i[i] & ~src_q[i]) |
                               (pending_q[i] & ~(ack_clear && (irq_id_q == IdxW'(i))));
            end else begin
                pending_d[i] = src_i[i];
            end
        end
    end

    // Configuration, line history and pending registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ie_q      <= '0;
            edge_q    <= '0;
            shv_q     <= '0;
            src_q     <= '0;
            pending_q <= '0;
            for (int i = 0; i < int'(NumSrc); i++) begin
                level_q[i] <= '0;
            end
        end else begin
            ie_q      <= ie_d;
            edge_q    <= edge_d;
            shv_q     <= shv_d;
            src_q     <= src_d;
            pending_q <= pending_d;
            for (int i = 0; i < int'(NumSrc); i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    // FSM state and captured request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            irq_id_q    <= '0;
            irq_level_q <= '0;
            irq_shv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_id_q    <= irq_id_d;
            irq_level_q <= irq_level_d;
            irq_shv_q   <= irq_shv_d;
        end
    end

    // Outputs are only driven while a request is being presented.
    assign req_active  = (state_q == REQ);
    assign irq_o       = req_active ? ({{(NumSrc-1){1'b0}}, 1'b1} << irq_id_q) : '0;
    assign irq_id_o    = req_active ? irq_id_q : '0;
    assign irq_level_o = req_active ? irq_level_q : '0;
    assign irq_shv_o   = req_active & irq_shv_q;

endmodule
